// File: rtl/timer_pkg.sv
// Shared types and digit limits for the MM:SS countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } timer_state_t;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

endpackage

// File: rtl/counter_4bit_down.sv
// One BCD down-counting digit; wraps to MAX on borrow and saturates loads at MAX.
module counter_4bit_down #(
    parameter logic [3:0] MAX
) (
    input  logic       reset,
    input  logic       clk,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       borrow_in,
    output logic [3:0] value,
    output logic       zero
);

    logic [3:0] value_q;
    logic [3:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (load_value > MAX) ? MAX : load_value;
        end else if (borrow_in) begin
            value_d = (value_q == 4'd0) ? MAX : value_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == 4'd0);

endmodule

// File: rtl/countdown_timer_mmss.sv
// MM:SS countdown timer: run/pause FSM over a borrow-chained chain of four BCD digits.
module countdown_timer_mmss
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] load_min_t,
    input  logic [3:0] load_min_o,
    input  logic [3:0] load_sec_t,
    input  logic [3:0] load_sec_o,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic       running,
    output logic       expired,
    output logic       done
);

    timer_state_t state_q;
    timer_state_t state_d;
    logic         done_q;
    logic         done_d;
    logic         dec;

    logic zero_so;
    logic zero_st;
    logic zero_mo;
    logic zero_mt;
    logic b_st;
    logic b_mo;
    logic b_mt;
    logic count_zero;
    logic last_sec;

    // Each digit borrows only when every lower digit is sitting at zero.
    assign b_st = dec & zero_so;
    assign b_mo = b_st & zero_st;
    assign b_mt = b_mo & zero_mo;

    assign count_zero = zero_mt & zero_mo & zero_st & zero_so;
    assign last_sec   = zero_mt & zero_mo & zero_st & (sec_o == 4'd1);

    counter_4bit_down #(.MAX(ONES_MAX)) u_sec_o (
        .reset      (reset),
        .clk        (clk),
        .load       (load),
        .load_value (load_sec_o),
        .borrow_in  (dec),
        .value      (sec_o),
        .zero       (zero_so)
    );

    counter_4bit_down #(.MAX(TENS_MAX)) u_sec_t (
        .reset      (reset),
        .clk        (clk),
        .load       (load),
        .load_value (load_sec_t),
        .borrow_in  (b_st),
        .value      (sec_t),
        .zero       (zero_st)
    );

    counter_4bit_down #(.MAX(ONES_MAX)) u_min_o (
        .reset      (reset),
        .clk        (clk),
        .load       (load),
        .load_value (load_min_o),
        .borrow_in  (b_mo),
        .value      (min_o),
        .zero       (zero_mo)
    );

    counter_4bit_down #(.MAX(TENS_MAX)) u_min_t (
        .reset      (reset),
        .clk        (clk),
        .load       (load),
        .load_value (load_min_t),
        .borrow_in  (b_mt),
        .value      (min_t),
        .zero       (zero_mt)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        dec     = 1'b0;
        if (load) begin
            state_d = IDLE;
        end else if (pause && state_q == RUN) begin
            state_d = PAUSE;
        end else if (start && (state_q == IDLE || state_q == PAUSE)) begin
            if (count_zero) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else if (tick && state_q == RUN) begin
            dec = 1'b1;
            if (last_sec) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign running = (state_q == RUN);
    assign expired = (state_q == DONE);
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Scoreboard bench: each driven cycle queues its expected outputs; a negedge monitor checks them.
module tb_countdown_timer_mmss;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_min_t = 4'd0;
    logic [3:0] load_min_o = 4'd0;
    logic [3:0] load_sec_t = 4'd0;
    logic [3:0] load_sec_o = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic       running;
    logic       expired;
    logic       done;

    typedef struct {
        string       name;
        logic [15:0] digits;
        logic        running;
        logic        done;
        logic        expired;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    countdown_timer_mmss dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .load       (load),
        .load_min_t (load_min_t),
        .load_min_o (load_min_o),
        .load_sec_t (load_sec_t),
        .load_sec_o (load_sec_o),
        .start      (start),
        .pause      (pause),
        .min_t      (min_t),
        .min_o      (min_o),
        .sec_t      (sec_t),
        .sec_o      (sec_o),
        .running    (running),
        .expired    (expired),
        .done       (done)
    );

    // Monitor: the DUT output is valid on every negedge after a driven cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [15:0] act;
            e   = exp_q.pop_front();
            act = {min_t, min_o, sec_t, sec_o};
            vectors++;
            if (act !== e.digits || running !== e.running ||
                done !== e.done || expired !== e.expired) begin
                miscompares++;
                $display("FAIL %s: got %h run=%b done=%b exp=%b, want %h run=%b done=%b exp=%b",
                         e.name, act, running, done, expired,
                         e.digits, e.running, e.done, e.expired);
            end
        end
    end

    // Drive one cycle of commands, then queue what the outputs must be after that edge.
    task automatic cyc(input string nm, input logic rs, input logic ld,
                       input logic [15:0] pv, input logic st, input logic pa,
                       input logic tk, input logic [15:0] ed, input logic er,
                       input logic edn, input logic ee);
        exp_t e;
        @(negedge clk);
        reset = rs;
        load  = ld;
        {load_min_t, load_min_o, load_sec_t, load_sec_o} = pv;
        start = st;
        pause = pa;
        tick  = tk;
        @(posedge clk);
        #1;
        reset = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        tick  = 1'b0;
        e.name    = nm;
        e.digits  = ed;
        e.running = er;
        e.done    = edn;
        e.expired = ee;
        exp_q.push_back(e);
    endtask

    initial begin
        //       name          rs ld pv        st pa tk exp      run dn ex
        cyc("reset",          1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0);
        cyc("load_0003",      0, 1, 16'h0003, 0, 0, 0, 16'h0003, 0, 0, 0);
        cyc("start_0003",     0, 0, 16'h0000, 1, 0, 0, 16'h0003, 1, 0, 0);
        cyc("tick_0002",      0, 0, 16'h0000, 0, 0, 1, 16'h0002, 1, 0, 0);
        cyc("tick_0001",      0, 0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 0);
        cyc("tick_0000_done", 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 1);
        cyc("done_drops",     0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1);
        cyc("done_tick_ign",  0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 1);
        cyc("done_start_ign", 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1);

        cyc("load_1000",      0, 1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0);
        cyc("start_1000",     0, 0, 16'h0000, 1, 0, 0, 16'h1000, 1, 0, 0);
        cyc("borrow_0959",    0, 0, 16'h0000, 0, 0, 1, 16'h0959, 1, 0, 0);

        cyc("load_sat_5959",  0, 1, 16'h7FAC, 0, 0, 0, 16'h5959, 0, 0, 0);

        cyc("load_0100",      0, 1, 16'h0100, 0, 0, 0, 16'h0100, 0, 0, 0);
        cyc("start_0100",     0, 0, 16'h0000, 1, 0, 0, 16'h0100, 1, 0, 0);
        cyc("tick_0059",      0, 0, 16'h0000, 0, 0, 1, 16'h0059, 1, 0, 0);
        cyc("pause_0059",     0, 0, 16'h0000, 0, 1, 0, 16'h0059, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc("paused_tick",    0, 0, 16'h0000, 0, 0, 1, 16'h0059, 0, 0, 0);
        end
        cyc("resume",         0, 0, 16'h0000, 1, 0, 0, 16'h0059, 1, 0, 0);
        cyc("tick_0058",      0, 0, 16'h0000, 0, 0, 1, 16'h0058, 1, 0, 0);
        cyc("pause_tick",     0, 0, 16'h0000, 0, 1, 1, 16'h0058, 0, 0, 0);
        cyc("start_tick_pau", 0, 0, 16'h0000, 1, 0, 1, 16'h0058, 1, 0, 0);
        cyc("tick_0057",      0, 0, 16'h0000, 0, 0, 1, 16'h0057, 1, 0, 0);

        cyc("load_0000",      0, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0);
        cyc("start_zero",     0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 1);
        cyc("zero_done_drop", 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1);

        cyc("load_0006",      0, 1, 16'h0006, 0, 0, 0, 16'h0006, 0, 0, 0);
        cyc("start_0006",     0, 0, 16'h0000, 1, 0, 0, 16'h0006, 1, 0, 0);
        cyc("tick_0005",      0, 0, 16'h0000, 0, 0, 1, 16'h0005, 1, 0, 0);
        cyc("reset_tick",     1, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 0);
        cyc("reset_no_done",  0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0);

        cyc("load_0010",      0, 1, 16'h0010, 0, 0, 0, 16'h0010, 0, 0, 0);
        cyc("start_0010",     0, 0, 16'h0000, 1, 0, 0, 16'h0010, 1, 0, 0);
        cyc("load_tick",      0, 1, 16'h0030, 0, 0, 1, 16'h0030, 0, 0, 0);
        cyc("idle_tick_ign",  0, 0, 16'h0000, 0, 0, 1, 16'h0030, 0, 0, 0);
        cyc("start_0030",     0, 0, 16'h0000, 1, 0, 0, 16'h0030, 1, 0, 0);
        cyc("tick_0029",      0, 0, 16'h0000, 0, 0, 1, 16'h0029, 1, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
